// File: rtl/mul_product_combiner.sv
// rtl/mul_product_combiner.sv - assembles low 32 bits of a 32x32 product from 16x16 partials
// Two-stage pipeline into a credit-throttled result FIFO, carrying the destination tag.
module mul_product_combiner #(
  parameter int TAG_W     = 5,
  parameter int OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             M_en,
  input  logic             E_mul_issue,
  input  logic [TAG_W-1:0] E_mul_tag,
  input  logic             M_flush,
  input  logic [31:0]      M_mul_cell_p1,
  input  logic [31:0]      M_mul_cell_p2,
  input  logic [31:0]      M_mul_cell_p3,
  output logic             mul_stall,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             err_overflow
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int INF_W = CNT_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_DEPTH - 1);

  logic             s0_v_q;
  logic [TAG_W-1:0] s0_tag_q;
  logic             s1_v_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [31:0]      s1_p1_q;
  logic [15:0]      s1_cross_q;

  logic [31:0]      mem_data_q [OUT_DEPTH];
  logic [TAG_W-1:0] mem_tag_q  [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      last_data_q;
  logic [TAG_W-1:0] last_tag_q;
  logic             err_q;

  logic [INF_W-1:0] inflight;
  logic             issue, accept, push, pop, fifo_empty;
  logic [15:0]      cross_d;
  logic [31:0]      push_data;
  logic             unused_hi;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Upper partial-product halves only affect bits above 31 of the product.
  assign unused_hi = ^{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

  always_comb begin
    inflight   = INF_W'(s0_v_q) + INF_W'(s1_v_q) + INF_W'(count_q);
    mul_stall  = (inflight >= INF_W'(OUT_DEPTH));
    issue      = E_mul_issue & M_en;
    accept     = issue & ~mul_stall;
    push       = s1_v_q & ~M_flush;
    fifo_empty = (count_q == '0);
    pop        = ~fifo_empty & res_ready;
    cross_d    = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
    push_data  = s1_p1_q + {s1_cross_q, 16'h0000};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_v_q      <= 1'b0;
      s0_tag_q    <= '0;
      s1_v_q      <= 1'b0;
      s1_tag_q    <= '0;
      s1_p1_q     <= '0;
      s1_cross_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_data_q <= '0;
      last_tag_q  <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_tag_q[i]  <= '0;
      end
    end else begin
      // A flush kills S0/S1 but a same-cycle issue still enters S0.
      s0_v_q <= accept;
      if (accept) s0_tag_q <= E_mul_tag;
      s1_v_q <= s0_v_q & ~M_flush;
      if (s0_v_q) begin
        s1_tag_q   <= s0_tag_q;
        s1_p1_q    <= M_mul_cell_p1;
        s1_cross_q <= cross_d;
      end
      if (push) begin
        mem_data_q[wr_ptr_q] <= push_data;
        mem_tag_q[wr_ptr_q]  <= s1_tag_q;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        last_data_q <= mem_data_q[rd_ptr_q];
        last_tag_q  <= mem_tag_q[rd_ptr_q];
        rd_ptr_q    <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      err_q   <= err_q | (issue & mul_stall);
    end
  end

  assign res_valid    = ~fifo_empty;
  assign res_data     = fifo_empty ? last_data_q : mem_data_q[rd_ptr_q];
  assign res_tag      = fifo_empty ? last_tag_q : mem_tag_q[rd_ptr_q];
  assign err_overflow = err_q;

endmodule

// File: tb/tb_mul_product_combiner.sv
// tb/tb_mul_product_combiner.sv - scoreboard bench for mul_product_combiner
// Reference tracks accepted ops by age; expected results are plain 64-bit products truncated.
module tb_mul_product_combiner;
  localparam int TAG_W = 5;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             M_en = 1'b0;
  logic             E_mul_issue = 1'b0;
  logic [TAG_W-1:0] E_mul_tag = '0;
  logic             M_flush = 1'b0;
  logic [31:0]      p1 = '0, p2 = '0, p3 = '0;
  logic [31:0]      op_a = '0, op_b = '0;
  logic             mul_stall, res_valid, err_overflow;
  logic             res_ready = 1'b0;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;

  always #5 clk = ~clk;

  mul_product_combiner #(.TAG_W(TAG_W), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .M_en(M_en), .E_mul_issue(E_mul_issue),
    .E_mul_tag(E_mul_tag), .M_flush(M_flush),
    .M_mul_cell_p1(p1), .M_mul_cell_p2(p2), .M_mul_cell_p3(p3),
    .mul_stall(mul_stall), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .err_overflow(err_overflow)
  );

  // Upstream multiplier cell: registers partials on M_en, holds otherwise.
  always @(posedge clk) begin
    if (M_en) begin
      p1 <= {16'h0, op_a[15:0]} * {16'h0, op_b[15:0]};
      p2 <= {16'h0, op_a[15:0]} * {16'h0, op_b[31:16]};
      p3 <= {16'h0, op_a[31:16]} * {16'h0, op_b[15:0]};
    end
  end

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   n1 = 0, n2 = 0, err_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit iss, input bit men, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input bit fl, input bit rdy, input bit rst);
    int fifo_n;
    bit stall_p, acc;
    logic [63:0] full;
    @(posedge clk);
    #1;
    stall_p = (exp_q.size() >= DEPTH);
    fifo_n  = exp_q.size() - int'(n1) - int'(n2);
    chk("mul_stall", 32'(mul_stall), 32'(stall_p));
    chk("res_valid", 32'(res_valid), 32'(fifo_n > 0));
    chk("err_overflow", 32'(err_overflow), 32'(err_m));
    acc = 0;
    if (rst) begin
      exp_q.delete();
      n1 = 0; n2 = 0; err_m = 0;
    end else begin
      acc = iss && men && !stall_p;
      if (iss && men && stall_p) err_m = 1;
      if (fl) begin
        if (n1) void'(exp_q.pop_back());
        if (n2) void'(exp_q.pop_back());
      end
      if (acc) begin
        full = 64'(a) * 64'(b);
        exp_q.push_back('{data: full[31:0], tag: tag});
      end
      n2 = n1 && !fl;
      n1 = acc;
    end
    reset       = rst;
    E_mul_issue = iss;
    M_en        = men;
    op_a        = a;
    op_b        = b;
    E_mul_tag   = tag;
    M_flush     = fl;
    res_ready   = rdy;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 1, 32'h0, 32'h0, '0, 0, rdy, 0);
  endtask

  // Monitor: a handshake seen before the edge consumes the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=0x%08h tag=%0d required=none", res_data, res_tag);
        end else begin
          e = exp_q.pop_front();
          chk("res_data", res_data, e.data);
          chk("res_tag", 32'(res_tag), 32'(e.tag));
        end
      end
    end
  end

  logic [31:0] edge_vals [6];

  initial begin
    logic [31:0] a, b;
    edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'hFFFF_FFFF;
    edge_vals[2] = 32'h0001_8000; edge_vals[3] = 32'h0000_FFFF;
    edge_vals[4] = 32'hFFFF_0000; edge_vals[5] = 32'h8000_0001;

    step(0, 0, 0, 0, '0, 0, 0, 1);
    idle(1, 1);
    chk("reset_res_data", res_data, 32'h0);
    chk("reset_res_tag", 32'(res_tag), 32'h0);

    step(1, 1, 32'h0001_2345, 32'h0000_0010, 5'd7, 0, 1, 0);
    idle(4, 1);

    step(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 1, 0);
    step(1, 1, 32'h0001_8000, 32'h0001_8000, 5'd4, 0, 1, 0);
    idle(4, 1);

    for (int i = 0; i < DEPTH; i++)
      step(1, 1, 32'h100 + 32'(i), 32'h3 + 32'(i), 5'(10 + i), 0, 0, 0);
    idle(3, 0);
    step(1, 1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd31, 0, 0, 0);
    idle(2, 0);
    idle(6, 1);

    step(1, 1, 32'h1111_1111, 32'h2, 5'd1, 0, 1, 0);
    step(1, 1, 32'h2222_2222, 32'h3, 5'd2, 0, 1, 0);
    step(1, 1, 32'h3333_3333, 32'h5, 5'd3, 1, 1, 0);
    idle(5, 1);

    for (int i = 0; i < 3; i++)
      step(1, 1, 32'hABC0 + 32'(i), 32'h77, 5'(20 + i), 0, 0, 0);
    idle(1, 0);
    step(0, 0, 0, 0, '0, 0, 0, 1);
    idle(1, 0);
    chk("post_reset_res_data", res_data, 32'h0);
    chk("post_reset_res_tag", 32'(res_tag), 32'h0);
    idle(3, 1);

    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom();
      b = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom();
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 85, a, b, 5'($urandom()),
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 60, $urandom_range(0, 199) == 0);
    end

    for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1, 1);
    chk("drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
